dsp_frame_packer: RTL

Downstream egress stage of the DSP chiplet. It accepts complex result samples from `interface1` over the `dma_real`/`dma_imag`/`dma_valid`/`dma_ack` handshake. It packs each block of N samples into a framed 32-bit word stream: a header word, N sample words and an optional checksum trailer. The stream is presented to the off-chip link through a valid/ready port, and a small input FIFO decouples the link's backpressure from the interface.

---
 rtl/dsp_frame_packer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dsp_frame_packer.sv
// Packs blocks of N complex samples into {header, N sample words, [checksum]} 32-bit frames behind a small input FIFO.
// Optional trailer checksum controlled by FRAME_CHECKSUM_EN; one word/cycle, out_* held stable while out_ready is low.
module dsp_frame_packer #(
  parameter int DATA_WIDTH = 12,
  parameter int N          = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dma_real,
  input  logic [DATA_WIDTH-1:0] dma_imag,
  input  logic                  dma_valid,
  output logic                  dma_ack,
  output logic [31:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
`ifdef FRAME_CHECKSUM_EN
    DATA,
    TRAILER
`else
    DATA
`endif
  } state_t;

  state_t          state_q;
  logic [7:0]      seq_q;
  logic [CW-1:0]   cnt_q;
`ifdef FRAME_CHECKSUM_EN
  logic [31:0]     csum_q;
`endif

  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            rdy_q;

  logic            push, pop, fifo_nempty;
  logic [31:0]     fifo_head, sample_word;

  assign sample_word = {16'($signed(dma_real)), 16'($signed(dma_imag))};
  assign fifo_nempty = (count_q != '0);
  assign fifo_head   = mem_q[rd_ptr_q];

  // rdy_q keeps ack low during reset and for the first edge afterwards.
  assign dma_ack = rdy_q && (count_q != FULL_CNT);
  assign push    = dma_valid && dma_ack;
  assign pop     = (state_q == DATA) && fifo_nempty && out_ready;
  assign busy    = (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sample_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      seq_q   <= '0;
      cnt_q   <= '0;
`ifdef FRAME_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (fifo_nempty) state_q <= HEADER;
        HEADER: if (out_ready) begin
          cnt_q   <= '0;
`ifdef FRAME_CHECKSUM_EN
          csum_q  <= '0;
`endif
          state_q <= DATA;
        end
        DATA: if (pop) begin
          cnt_q <= cnt_q + 1'b1;
`ifdef FRAME_CHECKSUM_EN
          csum_q <= csum_q ^ fifo_head;
          if (cnt_q == LAST_IDX) state_q <= TRAILER;
`else
          if (cnt_q == LAST_IDX) begin
            state_q <= IDLE;
            seq_q   <= seq_q + 8'd1;
          end
`endif
        end
`ifdef FRAME_CHECKSUM_EN
        TRAILER: if (out_ready) begin
          state_q <= IDLE;
          seq_q   <= seq_q + 8'd1;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state and the FIFO head only.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    case (state_q)
      HEADER: begin
        out_valid = 1'b1;
        out_data  = {16'hA55A, seq_q, 8'(N - 1)};
      end
      DATA: begin
        out_valid = fifo_nempty;
        out_data  = fifo_head;
`ifndef FRAME_CHECKSUM_EN
        out_last  = (cnt_q == LAST_IDX);
`endif
      end
`ifdef FRAME_CHECKSUM_EN
      TRAILER: begin
        out_valid = 1'b1;
        out_data  = csum_q;
        out_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
